// File: rtl/microcode_sequencer.sv
// Top-level core sequencer: fetches an instruction, waits out the microcode ROM latency,
// then steps the execute datapath through the microcode word's cycles and owns the PC.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_FETCH   | imem_req high at pc, waiting for imem_ack (with timeout)
// S_DECODE  | one quiet cycle covering the decoder ROM latency
// S_EXECUTE | exec_valid high, exec_step walks 0..limit, retires on last
// S_TRAP    | sticky error, everything frozen until reset
module microcode_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    input  logic [31:0] microcode,
    output logic        exec_valid,
    output logic [3:0]  exec_step,
    input  logic        dmem_busy,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic        retire,
    output logic        trap,
    output logic [1:0]  trap_cause
);

    typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXECUTE, S_TRAP} state_t;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [15:0] TIMER_LOAD = (FETCH_TIMEOUT == 0) ? 16'd0 : 16'(FETCH_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic        run;
    logic [31:0] pc_nxt, instr_nxt;
    logic [3:0]  step, step_nxt, limit, limit_nxt;
    logic        may_stall, may_stall_nxt;
    logic [1:0]  cause, cause_nxt;
    logic [15:0] timer, timer_nxt;

    assign imem_addr  = pc;
    assign exec_step  = step;
    assign trap       = (state == S_TRAP);
    assign trap_cause = cause;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            run         <= 1'b0;
            pc          <= RESET_PC;
            instruction <= NOP;
            step        <= 4'd0;
            limit       <= 4'd0;
            may_stall   <= 1'b0;
            cause       <= 2'd0;
            timer       <= TIMER_LOAD;
        end else begin
            state       <= state_nxt;
            run         <= 1'b1;
            pc          <= pc_nxt;
            instruction <= instr_nxt;
            step        <= step_nxt;
            limit       <= limit_nxt;
            may_stall   <= may_stall_nxt;
            cause       <= cause_nxt;
            timer       <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        instr_nxt     = instruction;
        step_nxt      = step;
        limit_nxt     = limit;
        may_stall_nxt = may_stall;
        cause_nxt     = cause;
        timer_nxt     = TIMER_LOAD;
        imem_req      = 1'b0;
        exec_valid    = 1'b0;
        retire        = 1'b0;

        case (state)
            S_FETCH: begin
                // run is low for the cycle right after reset, so the request starts one cycle later
                if (run) begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        instr_nxt = imem_rdata;
                        state_nxt = S_DECODE;
                    end else if (FETCH_TIMEOUT != 0 && timer == 16'd0) begin
                        state_nxt = S_TRAP;
                        cause_nxt = 2'd2;
                    end else begin
                        timer_nxt = timer - 16'd1;
                    end
                end
            end
            S_DECODE: begin
                if (microcode == 32'd0) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'd1;
                end else begin
                    limit_nxt     = microcode[31:28];
                    may_stall_nxt = microcode[27];
                    step_nxt      = 4'd0;
                    state_nxt     = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                exec_valid = 1'b1;
                if (may_stall && dmem_busy) begin
                    step_nxt = step;
                end else if (step < limit) begin
                    step_nxt = step + 4'd1;
                end else if (branch_taken && branch_target[1:0] != 2'b00) begin
                    state_nxt = S_TRAP;
                    cause_nxt = 2'd3;
                    step_nxt  = 4'd0;
                end else begin
                    retire    = 1'b1;
                    pc_nxt    = branch_taken ? branch_target : pc + 32'd4;
                    step_nxt  = 4'd0;
                    state_nxt = S_FETCH;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed scenarios plus randomized instructions, checked
// against an instruction-level model of PC flow and expected micro-step sequences.
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] microcode;
    logic        exec_valid;
    logic [3:0]  exec_step;
    logic        dmem_busy;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        retire;
    logic        trap;
    logic [1:0]  trap_cause;

    logic [31:0] rom_word;
    logic [31:0] model_pc;
    int          stall_plan [16];
    int          passed = 0;
    int          total  = 0;

    assign microcode = rom_word;

    always #5 clk = ~clk;

    microcode_sequencer #(.RESET_PC(32'h100), .FETCH_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instruction(instruction), .microcode(microcode),
        .exec_valid(exec_valid), .exec_step(exec_step), .dmem_busy(dmem_busy),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .pc(pc), .retire(retire), .trap(trap), .trap_cause(trap_cause)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Asserts reset for two edges, checks the reset values and the first request after release.
    task automatic do_reset();
        rst_n = 1'b0; imem_ack = 1'b0; dmem_busy = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        chk("rst_pc", pc, 32'h100);
        chk("rst_instr", instruction, 32'h13);
        chk("rst_strobes", 32'({imem_req, exec_valid, retire, trap}), 32'd0);
        chk("rst_step", 32'(exec_step), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", 32'(imem_req), 32'd1);
        chk("post_rst_trap", 32'(trap), 32'd0);
        model_pc = 32'h100;
    endtask

    task automatic run_instr(input int delay, input logic [31:0] mc, input logic br, input logic [31:0] tgt);
        logic [31:0] ins;
        int          lim;
        bit          can_stall;
        bit          mis;
        ins       = $urandom;
        lim       = int'(mc[31:28]);
        can_stall = mc[27];
        mis       = br && (tgt[1:0] != 2'b00);
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, model_pc);
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0; imem_rdata = $urandom;
            @(negedge clk);
            chk("fetch_wait_req", 32'(imem_req), 32'd1);
        end
        imem_ack = 1'b1; imem_rdata = ins; rom_word = mc;
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = $urandom;
        chk("decode_quiet", 32'({imem_req, exec_valid, retire}), 32'd0);
        chk("instr_reg", instruction, ins);
        @(negedge clk);
        for (int s = 0; s <= lim; s++) begin
            int holds;
            holds = can_stall ? stall_plan[s] : 0;
            for (int k = 0; k <= holds; k++) begin
                bit last_go;
                last_go       = (s == lim) && (k == holds);
                dmem_busy     = can_stall ? (k < holds) : 1'($urandom_range(0, 1));
                branch_taken  = (s == lim) ? br : 1'($urandom_range(0, 1));
                branch_target = (s == lim) ? tgt : $urandom;
                #1;
                chk("exec_valid", 32'(exec_valid), 32'd1);
                chk("exec_step", 32'(exec_step), 32'(s));
                chk("retire", 32'(retire), 32'(last_go && !mis));
                @(negedge clk);
            end
        end
        dmem_busy = 1'b0; branch_taken = 1'b0;
        if (mis) begin
            chk("mis_trap", 32'(trap), 32'd1);
            chk("mis_cause", 32'(trap_cause), 32'd3);
            chk("mis_pc", pc, model_pc);
        end else begin
            model_pc = br ? tgt : model_pc + 32'd4;
            chk("next_pc", pc, model_pc);
            chk("no_trap", 32'(trap), 32'd0);
            chk("refetch_req", 32'(imem_req), 32'd1);
            chk("refetch_exec", 32'(exec_valid), 32'd0);
        end
    endtask

    task automatic check_frozen(input logic [1:0] cause, input logic [31:0] frozen_pc);
        for (int i = 0; i < 3; i++) begin
            chk("trap_hold", 32'(trap), 32'd1);
            chk("trap_cause_hold", 32'(trap_cause), 32'(cause));
            chk("trap_quiet", 32'({imem_req, exec_valid, retire}), 32'd0);
            chk("trap_pc", pc, frozen_pc);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; rom_word = 32'd3;
        dmem_busy = 1'b0; branch_taken = 1'b0; branch_target = 32'd0; model_pc = 32'h100;
        foreach (stall_plan[i]) stall_plan[i] = 0;

        do_reset();

        // single-step instruction: three-cycle turnaround
        run_instr(0, 32'h0000_0003, 1'b0, 32'd0);

        // three steps, step 1 stalled for two cycles
        stall_plan[1] = 2;
        run_instr(0, 32'h2800_0001, 1'b0, 32'd0);
        stall_plan[1] = 0;

        run_instr(1, 32'h1000_0005, 1'b1, 32'h40);

        // ack on the final allowed fetch cycle must win over the timeout
        run_instr(3, 32'h0000_0007, 1'b0, 32'd0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] mc;
            logic        br;
            mc = $urandom | 32'h1;
            br = 1'($urandom_range(0, 1));
            foreach (stall_plan[i]) stall_plan[i] = $urandom_range(0, 2);
            run_instr($urandom_range(0, 3), mc, br, $urandom & 32'hFFFF_FFFC);
        end
        foreach (stall_plan[i]) stall_plan[i] = 0;

        // PC wrap-around
        run_instr(0, 32'h0000_0003, 1'b1, 32'hFFFF_FFFC);
        run_instr(0, 32'h0000_0003, 1'b0, 32'd0);
        chk("wrap_pc", pc, 32'd0);

        // misaligned redirect traps without retiring
        run_instr(0, 32'h1000_0001, 1'b1, 32'h42);
        check_frozen(2'd3, model_pc);

        // null microcode
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; rom_word = 32'd0;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("ill_decode_exec", 32'(exec_valid), 32'd0);
        @(negedge clk);
        chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        check_frozen(2'd1, 32'h100);
        chk("ill_instr_frozen", instruction, 32'hDEAD_BEEF);

        // fetch timeout
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_wait_req", 32'(imem_req), 32'd1);
            chk("to_no_trap", 32'(trap), 32'd0);
        end
        @(negedge clk);
        chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(trap_cause), 32'd2);
        check_frozen(2'd2, 32'h100);

        // reset during execute step 1
        do_reset();
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678; rom_word = 32'h3000_0001;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("mid_step0", 32'(exec_step), 32'd0);
        @(negedge clk);
        chk("mid_step1", 32'(exec_step), 32'd1);
        chk("mid_valid", 32'(exec_valid), 32'd1);
        do_reset();
        run_instr(0, 32'h1000_0003, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/microcode_sequencer.md
Name: microcode_sequencer

Overview:
- Top-level control FSM for the core. Fetches each instruction from instruction memory and holds it stable on the decoder input.
- Waits out the decoder's one-cycle microcode ROM latency, then steps the execute datapath through the microcode word's cycles.
- Owns the PC (sequential or redirected), handles data-memory stalls, and traps on the null/illegal microcode entry.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FETCH_TIMEOUT, 16, cycles without imem_ack before a fetch trap; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  32  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  32  fetched instruction
- instruction  out  32  instruction register, drives the decoder
- microcode  in  32  decoder ROM output, valid one clk after instruction changes
- exec_valid  out  1  execute datapath enabled this cycle
- exec_step  out  4  current micro-step index, 0-based
- dmem_busy  in  1  data memory stall request
- branch_taken  in  1  PC redirect request, sampled on the last execute step
- branch_target  in  32  redirect address
- pc  out  32  current instruction address
- retire  out  1  one-cycle pulse when an instruction completes
- trap  out  1  sticky error flag
- trap_cause  out  2  0 none, 1 illegal, 2 fetch timeout, 3 misaligned target

Behaviour:
- Microcode fields consumed here:
  - [31:28] = step count minus 1 (0..15).
  - [27] = step may stall on dmem_busy.
  - microcode == 0 means null/illegal.
- Reset (rst_n low at posedge) values:
  - state=FETCH, pc=RESET_PC, instruction=32'h0000_0013 (NOP)
  - imem_req=0, exec_valid=0, exec_step=0, retire=0, trap=0, trap_cause=0
  - Reset has priority over every other event and aborts any state, including mid-fetch and mid-execute.
- FETCH:
  - imem_req=1 and imem_addr=pc. The request stays high while waiting and drops in the cycle after the ack.
  - On imem_ack: instruction<=imem_rdata, go to DECODE.
  - The timeout counter counts cycles in FETCH. If it reaches FETCH_TIMEOUT without an ack: go to TRAP, cause=2.
  - An ack arriving in the same cycle the counter hits the limit wins; no trap.
- DECODE: exactly one cycle, no outputs asserted; covers ROM latency.
  - Next cycle, microcode==0 → TRAP, cause=1.
  - Otherwise latch the step limit from [31:28], set exec_step=0, go to EXECUTE.
- EXECUTE:
  - exec_valid=1 and exec_step = current step.
  - If [27]=1 and dmem_busy=1: hold exec_step, keep exec_valid=1, do not advance.
  - Otherwise, when exec_step < limit: exec_step increments.
  - Otherwise this is the last step:
    - retire=1 for this one cycle.
    - pc <= branch_taken ? branch_target : pc+4, with wrap-around mod 2^32.
    - Next state FETCH.
  - branch_taken on any non-last step is ignored.
- Misaligned redirect: branch_taken with branch_target[1:0]!=0 on the last step:
  - No retire, pc unchanged, TRAP with cause=3.
- Latency: minimum instruction time = ack cycle + DECODE + (limit+1) execute cycles.
  - A 1-step instruction with ack in the first FETCH cycle retires every 3 cycles.
- TRAP:
  - trap=1 and trap_cause held.
  - All strobes 0; pc and instruction frozen.
  - Exit only via reset.
- instruction and microcode must stay stable from DECODE through the end of EXECUTE. The instruction register loads only on imem_ack in FETCH.
- exec_step is 4-bit and cannot overflow: limit ≤ 15.

Test Plan:
- Reset: hold rst_n=0 2 cycles with RESET_PC=32'h100 → pc=32'h100, imem_req=1 in the first cycle after release, trap=0, instruction=32'h13.
- Single-step: imem_ack immediate, microcode=32'h0000_0003 → exec_valid for 1 cycle with step 0, retire pulse, pc 0→4, next imem_req 3 cycles after the first.
- Multi-step with stall: microcode[31:28]=2, [27]=1, dmem_busy high 2 cycles during step 1 → steps seen 0,1,1,1,2; retire once; exec_valid high for 5 cycles.
- Branch: last step with branch_taken=1, target 32'h40 → pc=32'h40. target 32'h42 → trap=1, cause=3, no retire, pc unchanged.
- Illegal: microcode=0 after DECODE → trap=1, cause=1, exec_valid never asserts, imem_req stays 0 thereafter.
- Timeout and reset mid-op:
  - FETCH_TIMEOUT=4 with no ack → trap cause=2 after 4 cycles.
  - rst_n=0 during EXECUTE step 1 → all outputs at reset values on the next cycle.
